// File: rtl/csr_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_sequencer
// Description : Round-robin sequencer that funnels CSR read/write requests
//               from NUM_REQ requesters onto one shared CSR port. Each access
//               is checked for privilege/legality in a registered stage; legal
//               accesses get a one-cycle CSR strobe, then a held response.
//               Optional audit outputs (deny_count, last_deny_addr) are
//               enabled by defining CSR_AUDIT_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [2*NUM_REQ-1:0]        req_priv,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
  output logic                        csr_we,
  output logic                        csr_re,
  output logic [ADDR_W-1:0]           csr_addr,
  output logic [DATA_W-1:0]           csr_wdata,
  input  logic [DATA_W-1:0]           csr_rdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  resp_id,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_except
`ifdef CSR_AUDIT_LOG_EN
  ,
  output logic [15:0]                 deny_count,
  output logic [ADDR_W-1:0]           last_deny_addr
`endif
);

  localparam int c_id_w = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_id_w-1:0]   r_id;
  logic                r_write;
  logic                r_read;
  logic [1:0]          r_priv;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_except;

  logic                w_found;
  logic [c_id_w-1:0]   w_gidx;
  logic [c_id_w-1:0]   w_rr_nxt;
  logic                w_deny;
  logic                w_noop;

  // Round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == idx) && req_valid[j]) begin
          w_found = 1'b1;
          w_gidx  = j[c_id_w-1:0];
        end
      end
    end
    if (int'(w_gidx) == NUM_REQ - 1) w_rr_nxt = '0;
    else                             w_rr_nxt = w_gidx + 1'b1;
  end

  // Legality rules evaluated on the latched request
  assign w_deny = ((r_addr[9:8] == 2'b11) && (r_priv != 2'b11)) ||
                  (r_write && (r_addr[11:10] == 2'b11));
  assign w_noop = !r_read && !r_write;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs; ready is held low while in reset
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    csr_we      = 1'b0;
    csr_re      = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_gidx] = rst_n;
          w_state_nxt       = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_deny || w_noop) w_state_nxt = S_RESP;
        else                  w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        csr_we      = r_write;
        csr_re      = r_read;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latching, round-robin pointer update and response formation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_write  <= 1'b0;
      r_read   <= 1'b0;
      r_priv   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_except <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_rr_ptr <= w_rr_nxt;
            r_id     <= w_gidx;
            r_write  <= req_write[w_gidx];
            r_read   <= req_read[w_gidx];
            r_priv   <= req_priv[2*w_gidx +: 2];
            r_addr   <= req_addr[w_gidx*ADDR_W +: ADDR_W];
            r_wdata  <= req_wdata[w_gidx*DATA_W +: DATA_W];
          end
        end
        S_CHECK: begin
          r_except <= w_deny;
          r_rdata  <= '0;
        end
        S_ACCESS: begin
          // Read and write share the strobe cycle, so the read sees the old value
          r_rdata <= r_read ? csr_rdata : '0;
        end
        default: ;
      endcase
    end
  end

  assign csr_addr    = r_addr;
  assign csr_wdata   = r_wdata;
  assign resp_id     = r_id;
  assign resp_rdata  = r_rdata;
  assign resp_except = r_except;

`ifdef CSR_AUDIT_LOG_EN
  // Saturating count of denied accesses plus the most recent denied address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_count     <= '0;
      last_deny_addr <= '0;
    end else if ((r_state == S_CHECK) && w_deny) begin
      if (deny_count != 16'hFFFF) deny_count <= deny_count + 16'd1;
      last_deny_addr <= r_addr;
    end
  end
`endif

endmodule
`default_nettype wire
